// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
// Build option: define SPI_LSB_FIRST_EN to add the lsb_first port on spi_master_param.
package spi_pkg;

  // Transfer phases: select asserted before the first edge, clocking, select held after the last edge.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  // SPI modes encoded as {cpol, cpha}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Width of the slave index; a single slave still gets a 1-bit index.
  function automatic int spi_ss_w(input int num_ss);
    return (num_ss <= 1) ? 1 : $clog2(num_ss);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timing for spi_master_param.
// A transfer is cut into 2*DATA_W+2 segments of CLK_DIV clk cycles:
// segment 0 is the lead-in, segments 1..2*DATA_W are clocking half-periods,
// segment 2*DATA_W+1 is the trail-out. An SCLK edge happens at the end of
// segments 0..2*DATA_W-1; even segments end in a leading edge, odd in a trailing one.
module spi_clk_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge,
  output logic last_edge
);

  localparam int NUM_EDGES = 2 * DATA_W;
  localparam int SEG_MAX   = NUM_EDGES + 1;
  localparam int SEG_W     = $clog2(SEG_MAX + 1);
  localparam int DIV_W     = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_LAST      = SEG_W'(SEG_MAX);
  localparam logic [SEG_W-1:0] EDGE_END      = SEG_W'(NUM_EDGES);
  localparam logic [SEG_W-1:0] LAST_EDGE_SEG = SEG_W'(NUM_EDGES - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [SEG_W-1:0] seg_cnt;
  logic             edge_seg;

  // Divider and segment counters; held at zero whenever no transfer is running.
  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      div_cnt <= '0;
      seg_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      seg_cnt <= (seg_cnt == SEG_LAST) ? '0 : seg_cnt + SEG_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Segment-end strobes consumed by the master in the same cycle.
  always_comb begin
    tick       = run && (div_cnt == DIV_LAST);
    edge_seg   = (seg_cnt < EDGE_END);
    lead_edge  = tick && edge_seg && !seg_cnt[0];
    trail_edge = tick && edge_seg && seg_cnt[0];
    last_edge  = tick && (seg_cnt == LAST_EDGE_SEG);
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: all four CPOL/CPHA modes, DATA_W-bit words,
// CLK_DIV clk cycles per SCLK half-period, NUM_SS one-hot active-low selects.
// Build option: define SPI_LSB_FIRST_EN to add the lsb_first input (LSB-first transfers).
//
// Handshake: start is a request that is taken only in a cycle where busy=0 and
// ss_sel addresses an existing slave; there is no queuing. Once taken, busy stays
// high until the cycle in which done pulses for exactly one cycle, and rx_data is
// valid from that cycle until the next done. A start in the done cycle is taken.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int  DATA_W  = 8,
  parameter int  CLK_DIV = 2,
  parameter int  NUM_SS  = 1,
  localparam int SS_W    = spi_ss_w(NUM_SS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output spi_state_t        state_dbg
);

  localparam logic [SS_W:0] NUM_SS_V = (SS_W + 1)'(NUM_SS);

  spi_state_t        state;
  logic              cpha_q;
  logic              lsb_in;
  logic              lsb_q;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              run;
  logic              ss_ok;
  logic              tick;
  logic              lead_edge;
  logic              trail_edge;
  logic              last_edge;
  logic              shift_now;
  logic              sample_now;

  // Next bit to put on the wire from a word, in the selected order.
  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Drop the bit just sent so the following one moves into the send position.
  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Append a received bit so the word assembles in transmission order.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  assign run       = (state != IDLE);
  assign ss_ok     = ({1'b0, ss_sel} < NUM_SS_V);
  assign state_dbg = state;

  spi_clk_gen #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .tick       (tick),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .last_edge  (last_edge)
  );

  // CPHA=0 shifts on trailing edges (the first bit is already out), CPHA=1 on leading ones.
  always_comb begin
    shift_now  = cpha_q ? lead_edge : (trail_edge && !last_edge);
    sample_now = cpha_q ? trail_edge : lead_edge;
  end

  // Transfer FSM with all pin-side outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      ss_n    <= '1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      cpha_q  <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
`ifdef SPI_LSB_FIRST_EN
      lsb_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (start && ss_ok) begin
            state  <= LEAD;
            busy   <= 1'b1;
            ss_n   <= ~(NUM_SS'(1) << ss_sel);
            cpha_q <= cpha;
            rx_sh  <= '0;
`ifdef SPI_LSB_FIRST_EN
            lsb_q  <= lsb_first;
`endif
            if (!cpha) begin
              mosi  <= first_bit(tx_data, lsb_in);
              tx_sh <= shift_word(tx_data, lsb_in);
            end else begin
              mosi  <= 1'b0;
              tx_sh <= tx_data;
            end
          end
        end
        LEAD: begin
          if (tick) state <= XFER;
        end
        XFER: begin
          // The segment after the final edge ends without an edge.
          if (tick && !lead_edge && !trail_edge) state <= TRAIL;
        end
        TRAIL: begin
          if (tick) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            ss_n    <= '1;
            rx_data <= rx_sh;
          end
        end
        default: state <= IDLE;
      endcase
      if (lead_edge || trail_edge) sclk <= ~sclk;
      if (shift_now) begin
        mosi  <= first_bit(tx_sh, lsb_q);
        tx_sh <= shift_word(tx_sh, lsb_q);
      end
      if (sample_now) rx_sh <= shift_in(rx_sh, miso, lsb_q);
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed and randomized transfers against a bench-side SPI slave model.
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 2;
  localparam int NUM_SS  = 5;
  localparam int SS_W    = spi_ss_w(NUM_SS);
  localparam int DONE_K  = 1 + CLK_DIV * (2 * DATA_W + 2);
  localparam int BUDGET  = 4 * DONE_K;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              start   = 1'b0;
  logic              cpol    = 1'b0;
  logic              cpha    = 1'b0;
  logic [SS_W-1:0]   ss_sel  = '0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              miso    = 1'b0;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first = 1'b0;
`endif
  logic              sclk;
  logic              mosi;
  logic [NUM_SS-1:0] ss_n;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  spi_state_t        state_dbg;

  spi_master_param #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .NUM_SS  (NUM_SS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cpol      (cpol),
    .cpha      (cpha),
    .ss_sel    (ss_sel),
    .tx_data   (tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int                assert_cnt = 0;
  int                fail_cnt   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_rx = '0;

  // current request as seen by the model
  logic              m_cpol, m_cpha, m_lsb;
  int                m_sel;
  logic [DATA_W-1:0] m_tx;

  // per-transfer observations
  int                done_k, first_edge_k, edge_cnt, rise_cnt, ss_bad;
  logic              first_mosi;
  logic [DATA_W-1:0] mosi_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Position in the word of the i-th bit on the wire.
  function automatic int bit_pos(input int i, input logic lsb);
    return lsb ? i : DATA_W - 1 - i;
  endfunction

  // Expected select pattern: only the addressed line low.
  function automatic logic [NUM_SS-1:0] sel_mask(input int sel);
    logic [NUM_SS-1:0] m;
    for (int i = 0; i < NUM_SS; i++) m[i] = (i != sel);
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge: present a request with start high.
  task automatic launch(input logic [1:0] mode, input int sel, input logic [DATA_W-1:0] tx,
                        input logic lsb);
    m_cpol = mode[1];
    m_cpha = mode[0];
    m_sel  = sel;
    m_tx   = tx;
    m_lsb  = lsb;
    cpol    = mode[1];
    cpha    = mode[0];
    ss_sel  = SS_W'(sel);
    tx_data = tx;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = lsb;
`endif
    start = 1'b1;
  endtask

  // Runs one accepted transfer with start already high, playing the slave.
  // sw: word the slave returns (ignored when loop_i, miso then mirrors mosi).
  // poke: extra start pulse while busy. chain: raise start again in the done cycle.
  task automatic run_xfer(input string tag, input logic [DATA_W-1:0] sw, input bit loop_i,
                          input bit poke, input bit chain, input logic [DATA_W-1:0] chain_tx);
    logic              prev_sclk;
    logic              leading;
    int                samples;
    logic [NUM_SS-1:0] exp_ss;
    logic [DATA_W-1:0] cur_tx;
    logic [DATA_W-1:0] exp_rx;
    cur_tx = m_tx;
    exp_ss = sel_mask(m_sel);
    exp_q.push_back(loop_i ? cur_tx : sw);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    done_k = 0; first_edge_k = 0; edge_cnt = 0; rise_cnt = 0; ss_bad = 0; samples = 0;
    mosi_word = '0;
    check({tag, "_busy_k1"}, 32'(busy), 32'(1));
    check({tag, "_ss_k1"}, 32'(ss_n), 32'(exp_ss));
    check({tag, "_sclk_k1"}, 32'(sclk), 32'(m_cpol));
    check({tag, "_done_k1"}, 32'(done), 32'(0));
    check({tag, "_rx_held"}, 32'(rx_data), 32'(last_rx));
    prev_sclk  = sclk;
    first_mosi = mosi;
    if (!m_cpha && !loop_i) miso = sw[bit_pos(0, m_lsb)];
    for (int k = 1; k <= BUDGET && done_k == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (done === 1'b1) begin
        done_k = k;
        if (chain) begin
          tx_data = chain_tx;
          m_tx    = chain_tx;
          start   = 1'b1;
        end
      end else begin
        if (ss_n !== exp_ss) ss_bad++;
        if (poke && k == 5) start = 1'b1;
        if (poke && k == 6) start = 1'b0;
        if (sclk !== prev_sclk) begin
          edge_cnt++;
          if (first_edge_k == 0) first_edge_k = k;
          if (sclk === 1'b1) rise_cnt++;
          leading = (edge_cnt % 2 == 1);
          if (leading == !m_cpha) begin
            if (samples < DATA_W) mosi_word[bit_pos(samples, m_lsb)] = mosi;
            samples++;
          end
          if (!loop_i) begin
            if (m_cpha && leading && (edge_cnt - 1) / 2 < DATA_W)
              miso = sw[bit_pos((edge_cnt - 1) / 2, m_lsb)];
            if (!m_cpha && !leading && edge_cnt / 2 < DATA_W)
              miso = sw[bit_pos(edge_cnt / 2, m_lsb)];
          end
          prev_sclk = sclk;
        end
        if (loop_i) miso = mosi;
      end
    end
    exp_rx = exp_q.pop_front();
    check({tag, "_done_at"}, 32'(done_k), 32'(DONE_K));
    check({tag, "_first_edge"}, 32'(first_edge_k), 32'(1 + CLK_DIV));
    check({tag, "_edges"}, 32'(edge_cnt), 32'(2 * DATA_W));
    check({tag, "_rises"}, 32'(rise_cnt), 32'(DATA_W));
    check({tag, "_ss_hold"}, 32'(ss_bad), 32'(0));
    check({tag, "_mosi_word"}, 32'(mosi_word), 32'(cur_tx));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
    check({tag, "_ss_release"}, 32'(ss_n), 32'({NUM_SS{1'b1}}));
    check({tag, "_busy_release"}, 32'(busy), 32'(0));
    last_rx = exp_rx;
    if (!chain) begin
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'(0));
      check({tag, "_sclk_idle"}, 32'(sclk), 32'(m_cpol));
      repeat (2) @(negedge clk);
      check({tag, "_no_queue"}, 32'(busy), 32'(0));
      check({tag, "_rx_keep"}, 32'(rx_data), 32'(exp_rx));
    end
  endtask

  // Request with an out-of-range slave index must be dropped.
  task automatic bad_sel(input string tag, input int sel);
    launch(SPI_MODE0, sel, DATA_W'($urandom), 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_ss"}, 32'(ss_n), 32'({NUM_SS{1'b1}}));
    repeat (3) @(negedge clk);
    check({tag, "_busy_later"}, 32'(busy), 32'(0));
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    check({tag, "_rx"}, 32'(rx_data), 32'(last_rx));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int               e;
    int               dcount;
    logic             p;
    logic [1:0]       mode;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'(0));
    check("rst_mosi", 32'(mosi), 32'(0));
    check("rst_ss", 32'(ss_n), 32'({NUM_SS{1'b1}}));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rx", 32'(rx_data), 32'(0));
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // reset at the 5th SCLK edge aborts the transfer
    launch(SPI_MODE2, 1, 8'h5A, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e = 0;
    p = sclk;
    for (int k = 0; k < BUDGET && e < 5; k++) begin
      @(negedge clk);
      if (sclk !== p) begin
        e++;
        p = sclk;
      end
    end
    check("abort_edge5", 32'(e), 32'(5));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_ss", 32'(ss_n), 32'({NUM_SS{1'b1}}));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_sclk", 32'(sclk), 32'(0));
    check("abort_rx", 32'(rx_data), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    rst  = 1'b1;
    cpol = 1'b0;
    dcount = 0;
    for (int k = 0; k < DONE_K + 5; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'(0));

    // mode 0 loopback
    launch(SPI_MODE0, 0, 8'hA5, 1'b0);
    run_xfer("m0_loop", '0, 1'b1, 1'b0, 1'b0, '0);

    // mode 3, miso tied high
    miso = 1'b1;
    launch(SPI_MODE3, 0, 8'h3C, 1'b0);
    run_xfer("m3_ones", 8'hFF, 1'b0, 1'b0, 1'b0, '0);

    // slave 2 only, then out-of-range indices
    launch(SPI_MODE1, 2, 8'h96, 1'b0);
    run_xfer("sel2", 8'h4E, 1'b0, 1'b0, 1'b0, '0);
    bad_sel("sel5", 5);
    bad_sel("sel7", 7);

    // start while busy is dropped; start in the done cycle chains
    launch(SPI_MODE0, 3, 8'hC3, 1'b0);
    run_xfer("chain_a", 8'h71, 1'b0, 1'b1, 1'b1, 8'h1E);
    run_xfer("chain_b", 8'hE8, 1'b0, 1'b1, 1'b0, '0);

    // randomized transfers
    for (int n = 0; n < 6; n++) begin
      mode = 2'($urandom_range(0, 3));
      launch(mode, $urandom_range(0, NUM_SS - 1), DATA_W'($urandom), 1'b0);
      run_xfer($sformatf("rnd%0d", n), DATA_W'($urandom), 1'($urandom_range(0, 1)),
               1'b0, 1'b0, '0);
    end

`ifdef SPI_LSB_FIRST_EN
    // LSB-first loopback
    launch(SPI_MODE0, 0, 8'h01, 1'b1);
    run_xfer("lsb_loop", '0, 1'b1, 1'b0, 1'b0, '0);
    check("lsb_first_bit", 32'(first_mosi), 32'(1));
    launch(SPI_MODE1, 4, DATA_W'($urandom), 1'b1);
    run_xfer("lsb_rnd", DATA_W'($urandom), 1'b0, 1'b0, 1'b0, '0);
`endif

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
